// File: rtl/uart_apb_stream_ctrl_if.sv
// APB master signals towards one CoreUARTapb plus the TX/RX byte streams
// facing fabric logic. The controller uses "master", the surroundings use "slave".
interface uart_apb_stream_ctrl_if;
   logic [4:0] PADDR;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;
   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       RX_READY;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR,
      input  TX_DATA, TX_VALID,
      output TX_READY,
      output RX_DATA, RX_VALID,
      input  RX_READY
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR,
      output TX_DATA, TX_VALID,
      input  TX_READY,
      input  RX_DATA, RX_VALID,
      output RX_READY
   );
endinterface

// File: rtl/uart_apb_stream_ctrl.sv
// APB sequencer that configures a CoreUARTapb and bridges it to RX/TX byte streams.
// Define UART_CTRL_FRAC_EN to add the fractional-baud (ctrl3) configuration write.
module uart_apb_stream_ctrl #(
   parameter logic [12:0] BAUD_VAL   = 13'd1,
   parameter bit          BIT8       = 1'b1,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          ODD_N_EVEN = 1'b0,
   parameter logic [2:0]  BAUD_FRAC  = 3'd0
) (
   input  logic                          PCLK,
   input  logic                          PRESET,
   uart_apb_stream_ctrl_if.master        bus,
   output logic                          CFG_DONE,
   output logic [3:0]                    ERR_STICKY,
   input  logic                          ERR_CLR
);

   localparam logic [4:0] ADDR_TX     = 5'h00;
   localparam logic [4:0] ADDR_RX     = 5'h04;
   localparam logic [4:0] ADDR_CTRL1  = 5'h08;
   localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
   localparam logic [4:0] ADDR_STATUS = 5'h10;
`ifdef UART_CTRL_FRAC_EN
   localparam logic [4:0] ADDR_CTRL3  = 5'h14;
`endif

   typedef enum logic [2:0] {
      ST_CFG1,
      ST_CFG2,
`ifdef UART_CTRL_FRAC_EN
      ST_CFG3,
`endif
      ST_POLL,
      ST_RXRD,
      ST_TXWR
   } state_t;

   state_t     state_reg,    state_next;
   logic       psel_reg,     psel_next;
   logic       penable_reg,  penable_next;
   logic       pwrite_reg,   pwrite_next;
   logic [4:0] paddr_reg,    paddr_next;
   logic [7:0] pwdata_reg,   pwdata_next;
   logic       cfg_done_reg, cfg_done_next;
   logic [3:0] err_reg,      err_next;
   logic       tx_full_reg,  tx_full_next;
   logic [7:0] tx_hold_reg,  tx_hold_next;
   logic       rx_valid_reg, rx_valid_next;
   logic [7:0] rx_data_reg,  rx_data_next;

   logic       xfer_done;
   logic       tx_ready;
   logic       unused_bits;

   // Address, direction and write data of the transfer issued from state s.
   function automatic logic [13:0] req_of(input state_t s, input logic [7:0] txd);
      logic [13:0] r;
      r = {ADDR_STATUS, 1'b0, 8'h00};
      case (s)
         ST_CFG1: r = {ADDR_CTRL1, 1'b1, BAUD_VAL[7:0]};
         ST_CFG2: r = {ADDR_CTRL2, 1'b1, BAUD_VAL[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
`ifdef UART_CTRL_FRAC_EN
         ST_CFG3: r = {ADDR_CTRL3, 1'b1, 5'b00000, BAUD_FRAC};
`endif
         ST_POLL: r = {ADDR_STATUS, 1'b0, 8'h00};
         ST_RXRD: r = {ADDR_RX, 1'b0, 8'h00};
         ST_TXWR: r = {ADDR_TX, 1'b1, txd};
         default: r = {ADDR_STATUS, 1'b0, 8'h00};
      endcase
      return r;
   endfunction

   assign xfer_done = psel_reg & penable_reg & bus.PREADY;
   assign tx_ready  = cfg_done_reg & ~tx_full_reg;

   always_comb begin
      state_next    = state_reg;
      psel_next     = psel_reg;
      penable_next  = penable_reg;
      pwrite_next   = pwrite_reg;
      paddr_next    = paddr_reg;
      pwdata_next   = pwdata_reg;
      cfg_done_next = cfg_done_reg;
      err_next      = err_reg;
      tx_full_next  = tx_full_reg;
      tx_hold_next  = tx_hold_reg;
      rx_valid_next = rx_valid_reg;
      rx_data_next  = rx_data_reg;

      if (tx_ready && bus.TX_VALID) begin
         tx_full_next = 1'b1;
         tx_hold_next = bus.TX_DATA;
      end
      if (rx_valid_reg && bus.RX_READY) begin
         rx_valid_next = 1'b0;
      end

      // Clear first so a coincident error set survives.
      if (ERR_CLR) begin
         err_next = 4'h0;
      end

      if (!psel_reg) begin
         // Only reached straight out of reset: open the first SETUP.
         psel_next    = 1'b1;
         penable_next = 1'b0;
         {paddr_next, pwrite_next, pwdata_next} = req_of(state_reg, tx_hold_reg);
      end else if (!penable_reg) begin
         penable_next = 1'b1;
      end else if (bus.PREADY) begin
         if (bus.PSLVERR) begin
            err_next[3] = 1'b1;
         end
         case (state_reg)
            ST_CFG1: state_next = ST_CFG2;
`ifdef UART_CTRL_FRAC_EN
            ST_CFG2: state_next = ST_CFG3;
            ST_CFG3: begin
               state_next    = ST_POLL;
               cfg_done_next = 1'b1;
            end
`else
            ST_CFG2: begin
               state_next    = ST_POLL;
               cfg_done_next = 1'b1;
            end
`endif
            ST_POLL: begin
               err_next[2:0] = err_next[2:0] | bus.PRDATA[4:2];
               // RX first so the UART receive buffer is drained before it overflows.
               if (bus.PRDATA[1] && !rx_valid_reg) begin
                  state_next = ST_RXRD;
               end else if (bus.PRDATA[0] && tx_full_reg) begin
                  state_next = ST_TXWR;
               end else begin
                  state_next = ST_POLL;
               end
            end
            ST_RXRD: begin
               rx_data_next  = bus.PRDATA;
               rx_valid_next = 1'b1;
               state_next    = ST_POLL;
            end
            ST_TXWR: begin
               tx_full_next = 1'b0;
               state_next   = ST_POLL;
            end
            default: state_next = ST_CFG1;
         endcase
         psel_next    = 1'b1;
         penable_next = 1'b0;
         {paddr_next, pwrite_next, pwdata_next} = req_of(state_next, tx_hold_reg);
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_reg    <= ST_CFG1;
         psel_reg     <= 1'b0;
         penable_reg  <= 1'b0;
         pwrite_reg   <= 1'b0;
         paddr_reg    <= 5'h00;
         pwdata_reg   <= 8'h00;
         cfg_done_reg <= 1'b0;
         err_reg      <= 4'h0;
         tx_full_reg  <= 1'b0;
         tx_hold_reg  <= 8'h00;
         rx_valid_reg <= 1'b0;
         rx_data_reg  <= 8'h00;
      end else begin
         state_reg    <= state_next;
         psel_reg     <= psel_next;
         penable_reg  <= penable_next;
         pwrite_reg   <= pwrite_next;
         paddr_reg    <= paddr_next;
         pwdata_reg   <= pwdata_next;
         cfg_done_reg <= cfg_done_next;
         err_reg      <= err_next;
         tx_full_reg  <= tx_full_next;
         tx_hold_reg  <= tx_hold_next;
         rx_valid_reg <= rx_valid_next;
         rx_data_reg  <= rx_data_next;
      end
   end

   assign bus.PSEL     = psel_reg;
   assign bus.PENABLE  = penable_reg;
   assign bus.PWRITE   = pwrite_reg;
   assign bus.PADDR    = paddr_reg;
   assign bus.PWDATA   = pwdata_reg;
   assign bus.TX_READY = tx_ready;
   assign bus.RX_DATA  = rx_data_reg;
   assign bus.RX_VALID = rx_valid_reg;
   assign CFG_DONE     = cfg_done_reg;
   assign ERR_STICKY   = err_reg;

   // Upper status bits carry nothing we act on; BAUD_FRAC only matters with ctrl3.
   assign unused_bits = ^{bus.PRDATA[7:5], BAUD_FRAC};

endmodule

// File: tb/tb_uart_apb_stream_ctrl.sv
// Directed bench: a behavioural APB slave stands in for the UART and logs
// every completed transfer; expected values are hand-computed constants.
module tb_uart_apb_stream_ctrl;

`ifdef UART_CTRL_FRAC_EN
   localparam int NCFG    = 3;
   localparam int CFG_LAT = 7;
`else
   localparam int NCFG    = 2;
   localparam int CFG_LAT = 5;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_done;
   logic [3:0] err_sticky;
   logic       err_clr;

   int total = 0;
   int bad   = 0;

   logic [7:0] status_val;
   logic [7:0] rx_byte;
   int         wait_cfg;
   logic       slverr_cfg;

   logic [4:0] log_addr[$];
   logic       log_wr[$];
   logic [7:0] log_data[$];
   int         log_len[$];
   int         stab_err;
   int         mon_wcnt;
   int         mon_len;
   logic [13:0] mon_held;

   uart_apb_stream_ctrl_if bus_if ();

   uart_apb_stream_ctrl #(
      .BAUD_VAL   (13'h545),
      .BIT8       (1'b1),
      .PARITY_EN  (1'b0),
      .ODD_N_EVEN (1'b0),
      .BAUD_FRAC  (3'd5)
   ) dut (
      .PCLK       (clk),
      .PRESET     (rst),
      .bus        (bus_if),
      .CFG_DONE   (cfg_done),
      .ERR_STICKY (err_sticky),
      .ERR_CLR    (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_wr.delete();
      log_data.delete();
      log_len.delete();
   endtask

   function automatic int count_acc(input logic [4:0] a, input logic w);
      int c = 0;
      for (int i = 0; i < log_addr.size(); i++)
         if (log_addr[i] == a && log_wr[i] == w) c++;
      return c;
   endfunction

   function automatic int first_idx(input logic [4:0] a, input logic w);
      for (int i = 0; i < log_addr.size(); i++)
         if (log_addr[i] == a && log_wr[i] == w) return i;
      return -1;
   endfunction

   function automatic logic [13:0] entry_at(input int i);
      if (i < 0 || i >= log_addr.size()) return 14'h3fff;
      return {log_addr[i], log_wr[i], log_data[i]};
   endfunction

   function automatic int len_at(input int i);
      if (i < 0 || i >= log_len.size()) return -1;
      return log_len[i];
   endfunction

   // APB slave model and transfer monitor, evaluated on the falling edge.
   initial begin
      bus_if.PREADY  = 1'b1;
      bus_if.PRDATA  = 8'h00;
      bus_if.PSLVERR = 1'b0;
      mon_wcnt = 0;
      mon_len  = 0;
      stab_err = 0;
      forever begin
         @(negedge clk);
         if (bus_if.PSEL === 1'b1 && bus_if.PENABLE === 1'b1) begin
            if (mon_len == 0) mon_held = {bus_if.PADDR, bus_if.PWRITE, bus_if.PWDATA};
            else if (mon_held !== {bus_if.PADDR, bus_if.PWRITE, bus_if.PWDATA}) stab_err++;
            mon_len++;
            bus_if.PRDATA  = (bus_if.PADDR == 5'h10) ? status_val :
                             (bus_if.PADDR == 5'h04) ? rx_byte : 8'h00;
            bus_if.PSLVERR = slverr_cfg;
            if (mon_wcnt < wait_cfg) begin
               bus_if.PREADY = 1'b0;
               mon_wcnt++;
            end else begin
               bus_if.PREADY = 1'b1;
               log_addr.push_back(bus_if.PADDR);
               log_wr.push_back(bus_if.PWRITE);
               log_data.push_back(bus_if.PWDATA);
               log_len.push_back(mon_len);
               mon_wcnt = 0;
               mon_len  = 0;
            end
         end else begin
            bus_if.PREADY  = 1'b1;
            bus_if.PSLVERR = 1'b0;
            bus_if.PRDATA  = 8'h00;
            mon_wcnt = 0;
            mon_len  = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ir;
      int it;
      logic saw_set;

      err_clr          = 1'b0;
      bus_if.TX_DATA   = 8'h00;
      bus_if.TX_VALID  = 1'b0;
      bus_if.RX_READY  = 1'b0;
      status_val       = 8'h00;
      rx_byte          = 8'h00;
      wait_cfg         = 0;
      slverr_cfg       = 1'b0;
      tick(3);

      check_val("rst_psel",     bus_if.PSEL,     0);
      check_val("rst_penable",  bus_if.PENABLE,  0);
      check_val("rst_pwrite",   bus_if.PWRITE,   0);
      check_val("rst_paddr",    bus_if.PADDR,    0);
      check_val("rst_pwdata",   bus_if.PWDATA,   0);
      check_val("rst_tx_ready", bus_if.TX_READY, 0);
      check_val("rst_rx_valid", bus_if.RX_VALID, 0);
      check_val("rst_rx_data",  bus_if.RX_DATA,  0);
      check_val("rst_cfg_done", cfg_done,        0);
      check_val("rst_err",      err_sticky,      0);

      // Configuration sequence and CFG_DONE latency from reset release.
      clear_log();
      rst = 1'b0;
      n = 0;
      while (cfg_done !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      check_val("cfg_done_lat", n, CFG_LAT);
      tick(3);
      check_val("cfg1_write", entry_at(0), {5'h08, 1'b1, 8'h45});
      check_val("cfg2_write", entry_at(1), {5'h0C, 1'b1, 8'h29});
`ifdef UART_CTRL_FRAC_EN
      check_val("cfg3_write", entry_at(2), {5'h14, 1'b1, 8'h05});
`endif
      check_val("first_poll", entry_at(NCFG), {5'h10, 1'b0, 8'h00});
      check_val("cfg_len",    len_at(0), 1);

      // TX byte accepted but held while the UART reports TXRDY=0.
      check_val("tx_ready_idle", bus_if.TX_READY, 1);
      bus_if.TX_DATA  = 8'hA5;
      bus_if.TX_VALID = 1'b1;
      tick(1);
      bus_if.TX_VALID = 1'b0;
      bus_if.TX_DATA  = 8'h00;
      check_val("tx_ready_full", bus_if.TX_READY, 0);
      clear_log();
      tick(20);
      check_val("tx_no_write", count_acc(5'h00, 1'b1), 0);
      check_val("poll_repeats", count_acc(5'h10, 1'b0) >= 5, 1);

      status_val = 8'h01;
      clear_log();
      n = 0;
      while (count_acc(5'h00, 1'b1) == 0 && n < 30) begin
         tick(1);
         n++;
      end
      check_val("tx_write_seen", n < 30, 1);
      tick(1);
      check_val("tx_ready_again", bus_if.TX_READY, 1);
      check_val("tx_write_data", entry_at(first_idx(5'h00, 1'b1)), {5'h00, 1'b1, 8'hA5});
      tick(10);
      check_val("tx_write_once", count_acc(5'h00, 1'b1), 1);

      // RX byte held while the consumer stalls; no further reads until it drains.
      status_val = 8'h02;
      rx_byte    = 8'h3C;
      clear_log();
      tick(20);
      check_val("rx_valid",     bus_if.RX_VALID, 1);
      check_val("rx_data",      bus_if.RX_DATA,  8'h3C);
      check_val("rx_one_read",  count_acc(5'h04, 1'b0), 1);
      tick(10);
      check_val("rx_hold_valid", bus_if.RX_VALID, 1);
      check_val("rx_hold_data",  bus_if.RX_DATA,  8'h3C);
      check_val("rx_hold_reads", count_acc(5'h04, 1'b0), 1);
      rx_byte = 8'h5A;
      bus_if.RX_READY = 1'b1;
      tick(1);
      bus_if.RX_READY = 1'b0;
      check_val("rx_pop", bus_if.RX_VALID, 0);
      tick(20);
      check_val("rx2_valid", bus_if.RX_VALID, 1);
      check_val("rx2_data",  bus_if.RX_DATA,  8'h5A);
      check_val("rx2_reads", count_acc(5'h04, 1'b0), 2);

      // Both paths ready: RX read must precede TX write; slave inserts 3 wait states.
      status_val = 8'h00;
      tick(4);
      bus_if.RX_READY = 1'b1;
      bus_if.TX_DATA  = 8'h77;
      bus_if.TX_VALID = 1'b1;
      tick(1);
      bus_if.RX_READY = 1'b0;
      bus_if.TX_VALID = 1'b0;
      status_val = 8'h03;
      rx_byte    = 8'h11;
      wait_cfg   = 3;
      clear_log();
      stab_err   = 0;
      tick(60);
      ir = first_idx(5'h04, 1'b0);
      it = first_idx(5'h00, 1'b1);
      check_val("prio_rx_seen",  ir >= 0, 1);
      check_val("prio_rx_first", (ir >= 0) && (it > ir), 1);
      check_val("prio_tx_data",  entry_at(it), {5'h00, 1'b1, 8'h77});
      check_val("prio_pen_len",  len_at(it), 4);
      check_val("prio_stable",   stab_err, 0);
      check_val("prio_rx_data",  bus_if.RX_DATA, 8'h11);

      // Sticky error bits, clear, and set-over-clear priority.
      wait_cfg   = 0;
      status_val = 8'h1C;
      slverr_cfg = 1'b1;
      tick(10);
      check_val("err_all", err_sticky, 4'hF);
      status_val = 8'h00;
      slverr_cfg = 1'b0;
      tick(4);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check_val("err_clr", err_sticky, 4'h0);
      status_val = 8'h04;
      err_clr    = 1'b1;
      saw_set    = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (err_sticky == 4'h1) saw_set = 1'b1;
      end
      check_val("err_set_wins", saw_set, 1);
      err_clr    = 1'b0;
      status_val = 8'h00;
      tick(4);

      // Reset during the ACCESS phase of a stalled TX write.
      bus_if.TX_DATA  = 8'h99;
      bus_if.TX_VALID = 1'b1;
      tick(1);
      bus_if.TX_VALID = 1'b0;
      status_val = 8'h01;
      wait_cfg   = 6;
      n = 0;
      while (!(bus_if.PSEL === 1'b1 && bus_if.PENABLE === 1'b1 &&
               bus_if.PADDR == 5'h00 && bus_if.PWRITE === 1'b1) && n < 60) begin
         tick(1);
         n++;
      end
      check_val("txwr_access_seen", n < 60, 1);
      rst = 1'b1;
      tick(1);
      check_val("rst_mid_psel",     bus_if.PSEL,     0);
      check_val("rst_mid_penable",  bus_if.PENABLE,  0);
      check_val("rst_mid_cfg_done", cfg_done,        0);
      check_val("rst_mid_tx_ready", bus_if.TX_READY, 0);
      tick(2);
      clear_log();
      wait_cfg = 0;
      rst = 1'b0;
      tick(14);
      check_val("restart_cfg1",   entry_at(0), {5'h08, 1'b1, 8'h45});
      check_val("hold_discarded", count_acc(5'h00, 1'b1), 0);
      check_val("restart_rx_empty", bus_if.RX_VALID, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
